cpu_trace_monitor: RTL

Parametrised, synthesisable commit-trace monitor that sits beside the single-cycle RISC-V `CPU` core and observes its debug outputs (PC, register-file write port). Each cycle it counts cycles and retired instructions, and it captures every architectural register write into a trace FIFO that a bench or debug port drains through a valid/ready handshake. It also detects a jump-to-self halt loop, so benches stop on a decided condition instead of a fixed delay.

---
 rtl/cpu_trace_monitor.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/cpu_trace_monitor.sv
// Commit-trace monitor for the single-cycle core: counts cycles and retired
// instructions, captures register-file writes into a first-word-fall-through
// FIFO drained by a valid/ready consumer, and latches a halt when the PC
// sits on the same address for HALT_CYCLES consecutive active edges.
module cpu_trace_monitor #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned HALT_CYCLES = 8,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [XLEN-1:0]  pc,
    input  logic             reg_write,
    input  logic [4:0]       rd_addr,
    input  logic [XLEN-1:0]  wr_data,
    output logic             trc_valid,
    input  logic             trc_ready,
    output logic [XLEN-1:0]  trc_pc,
    output logic [4:0]       trc_rd,
    output logic [XLEN-1:0]  trc_data,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count,
    output logic [CNT_W-1:0] drop_count,
    output logic             overflow,
    output logic             halted
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned RW = $clog2(HALT_CYCLES + 1);
    localparam int unsigned EW = 2 * XLEN + 5;

    localparam logic [AW:0]      PtrOne = (AW + 1)'(1);
    localparam logic [RW-1:0]    RepOne = RW'(1);
    localparam logic [RW-1:0]    RepMax = RW'(HALT_CYCLES);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [EW-1:0]    mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             pc_vld_q, pc_vld_d;
    logic [RW-1:0]    rep_q, rep_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] retire_q, retire_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             overflow_q, overflow_d;
    logic             halted_q, halted_d;

    logic fifo_empty, fifo_full;
    logic active, pop, capture, push, drop;
    logic [RW-1:0] rep_inc;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    assign active  = enable && !halted_q;
    assign pop     = !fifo_empty && trc_ready;
    assign capture = active && reg_write && (rd_addr != 5'd0);
    // A pop on the same edge frees the slot a full FIFO needs.
    assign push    = capture && (!fifo_full || pop);
    assign drop    = capture && fifo_full && !pop;
    assign rep_inc = rep_q + RepOne;

    // Next-state for counters, PC tracking, halt detection and FIFO pointers.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        pc_d       = pc_q;
        pc_vld_d   = pc_vld_q;
        rep_d      = rep_q;
        cycle_d    = cycle_q;
        retire_d   = retire_q;
        drop_d     = drop_q;
        overflow_d = overflow_q;
        halted_d   = halted_q;

        if (pop) begin
            rptr_d = rptr_q + PtrOne;
        end
        if (push) begin
            wptr_d = wptr_q + PtrOne;
        end

        if (active) begin
            if (cycle_q != CntMax) begin
                cycle_d = cycle_q + CntOne;
            end
            if (retire_q != CntMax) begin
                retire_d = retire_q + CntOne;
            end
            pc_d     = pc;
            pc_vld_d = 1'b1;
            if (pc_vld_q && (pc == pc_q)) begin
                rep_d = rep_inc;
                if (rep_inc == RepMax) begin
                    halted_d = 1'b1;
                end
            end else begin
                rep_d = '0;
            end
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_q != CntMax) begin
                    drop_d = drop_q + CntOne;
                end
            end
        end
    end

    // Control and counter state, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            pc_q       <= '0;
            pc_vld_q   <= 1'b0;
            rep_q      <= '0;
            cycle_q    <= '0;
            retire_q   <= '0;
            drop_q     <= '0;
            overflow_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            pc_q       <= pc_d;
            pc_vld_q   <= pc_vld_d;
            rep_q      <= rep_d;
            cycle_q    <= cycle_d;
            retire_q   <= retire_d;
            drop_q     <= drop_d;
            overflow_q <= overflow_d;
            halted_q   <= halted_d;
        end
    end

    // Trace storage; contents are don't-care until the pointers say otherwise.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= {pc, rd_addr, wr_data};
        end
    end

    assign trc_valid                   = !fifo_empty;
    assign {trc_pc, trc_rd, trc_data}  = mem_q[rptr_q[AW-1:0]];
    assign cycle_count                 = cycle_q;
    assign retire_count                = retire_q;
    assign drop_count                  = drop_q;
    assign overflow                    = overflow_q;
    assign halted                      = halted_q;

endmodule
